// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use stalls, redirect flushes,
// data-memory wait with timeout, and saturating stall/flush performance counters.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic [1:0]       PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             ClrCnt,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memwait_s, lw_stall_s, redirect_s;
  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic flush_d_s, flush_e_s, flush_w_s;

  // State, wait counter, sticky timeout flag and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Next-state: an ack always wins over the timeout check in the last wait cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = MEM_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      MEM_ERR: begin
        state_d = MEM_ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
    mem_timeout_d = (state_d == MEM_ERR);
  end

  // Pipeline control; a memory wait freezes E so its redirect is re-evaluated on release.
  always_comb begin
    lw_stall_s = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    redirect_s = (PCSrcE != 2'd0);
    case (state_q)
      RUN:      memwait_s = MemReqM && !MemAckM;
      MEM_WAIT: memwait_s = !MemAckM;
      MEM_ERR:  memwait_s = 1'b1;
      default:  memwait_s = 1'b0;
    endcase
    if (!rst_n) begin
      {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b0000;
      {flush_d_s, flush_e_s, flush_w_s}            = 3'b000;
    end else if (memwait_s) begin
      {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
      {flush_d_s, flush_e_s, flush_w_s}            = 3'b001;
    end else begin
      stall_f_s = lw_stall_s;
      stall_d_s = lw_stall_s;
      stall_e_s = 1'b0;
      stall_m_s = 1'b0;
      flush_d_s = redirect_s;
      flush_e_s = lw_stall_s || redirect_s;
      flush_w_s = 1'b0;
    end
  end

  // Saturating counters; a clear beats a same-cycle increment.
  always_comb begin
    if (ClrCnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      stall_cnt_d = (stall_f_s && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
      flush_cnt_d = ((flush_d_s || flush_e_s) && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CNT_ONE
                                                                           : flush_cnt_q;
    end
  end

  assign StallF     = stall_f_s;
  assign StallD     = stall_d_s;
  assign StallE     = stall_e_s;
  assign StallM     = stall_m_s;
  assign FlushD     = flush_d_s;
  assign FlushE     = flush_e_s;
  assign FlushW     = flush_w_s;
  assign MemTimeout = mem_timeout_q;
  assign StallCnt   = stall_cnt_q;
  assign FlushCnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a driver pushes expected outputs from a
// cycle-level reference model, a monitor pops and compares them mid-cycle.
module tb_pipeline_stall_ctrl;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, RdE;
  logic          ResultSrcE0, MemReqM, MemAckM, ClrCnt;
  logic [1:0]    PCSrcE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [CW-1:0] StallCnt, FlushCnt;

  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ClrCnt(ClrCnt), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]    ctl;  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    logic          mt;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: outstanding request, unacked cycles so far, error latch, counts.
  bit m_wait, m_err;
  int m_wcyc, m_sc, m_fc;

  task automatic step(input logic rn, input logic ld, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rde, input logic [1:0] pc, input logic req,
                      input logic ack, input logic clr);
    exp_t e;
    bit   mw, lw, br;
    @(negedge clk);
    rst_n = rn; ResultSrcE0 = ld; Rs1D = rs1; Rs2D = rs2; RdE = rde;
    PCSrcE = pc; MemReqM = req; MemAckM = ack; ClrCnt = clr;
    if (!rn) begin
      m_wait = 0; m_err = 0; m_wcyc = 0; m_sc = 0; m_fc = 0;
      e.ctl = 7'b0; e.mt = 1'b0; e.sc = '0; e.fc = '0;
    end else begin
      mw = m_err || ((m_wait || req) && !ack);
      lw = ld && (rde != 5'd0) && ((rs1 == rde) || (rs2 == rde));
      br = (pc != 2'd0);
      if (mw) e.ctl = 7'b1111001;
      else    e.ctl = {lw, lw, 1'b0, 1'b0, br, lw | br, 1'b0};
      e.mt = m_err;
      e.sc = CW'(m_sc);
      e.fc = CW'(m_fc);
      if (clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (e.ctl[6] && m_sc < CMAX) m_sc++;
        if ((e.ctl[2] || e.ctl[1]) && m_fc < CMAX) m_fc++;
      end
      if (!m_err) begin
        if (mw) begin
          m_wcyc++;
          m_wait = 1;
          if (m_wcyc == TO) m_err = 1;
        end else begin
          m_wait = 0;
          m_wcyc = 0;
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared 2 ns after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} === e.ctl) passed++;
        else $display("FAIL ctl t=%0t got=%b exp=%b", $time,
                      {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, e.ctl);
        checks++;
        if (MemTimeout === e.mt) passed++;
        else $display("FAIL memtimeout t=%0t got=%b exp=%b", $time, MemTimeout, e.mt);
        checks++;
        if (StallCnt === e.sc) passed++;
        else $display("FAIL stallcnt t=%0t got=%0d exp=%0d", $time, StallCnt, e.sc);
        checks++;
        if (FlushCnt === e.fc) passed++;
        else $display("FAIL flushcnt t=%0t got=%0d exp=%0d", $time, FlushCnt, e.fc);
      end
    end
  end

  initial begin
    logic       r_rn, r_ld, r_req, r_ack, r_clr;
    logic [4:0] r_rs1, r_rs2, r_rde;
    logic [1:0] r_pc;
    rst_n = 1'b0; ResultSrcE0 = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
    PCSrcE = 2'd0; MemReqM = 1'b0; MemAckM = 1'b0; ClrCnt = 1'b0;
    step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    // load-use, then RdE=0, branch, branch+load-use on Rs2D
    step(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd7, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // memory wait, ack 3 cycles after request, redirect during the wait
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(1);
    // timeout, held error, reset pulse
    for (int i = 0; i < TO + 3; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // counter saturation, then clear together with a stall
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // reset asserted in the second MEM_WAIT cycle
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // random traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      r_rn  = 1'($urandom_range(49, 0) != 0);
      r_ld  = 1'($urandom_range(1, 0));
      r_rs1 = 5'($urandom_range(3, 0));
      r_rs2 = 5'($urandom_range(3, 0));
      r_rde = 5'($urandom_range(3, 0));
      r_pc  = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      r_req = 1'($urandom_range(2, 0) == 0);
      r_ack = 1'($urandom_range(1, 0));
      r_clr = 1'($urandom_range(30, 0) == 0);
      step(r_rn, r_ld, r_rs1, r_rs2, r_rde, r_pc, r_req, r_ack, r_clr);
    end
    @(negedge clk);
    #4;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain got=%0d pending exp=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
